// File: rtl/logicnets_pkg.sv
// Shared defaults and types for the runtime-loadable LogicNets neuron table.
package logicnets_pkg;

  localparam int IN_W   = 7;
  localparam int OUT_W  = 2;
  localparam int PACK   = 8;
  localparam int DEPTH  = 1 << IN_W;
  localparam int NBEATS = DEPTH / PACK;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/logicnets_lut_ram.sv
// Neuron truth-table storage: one PACK-wide synchronous write port per beat,
// one asynchronous read port. No reset, so it maps onto distributed RAM.
module logicnets_lut_ram #(
  parameter int IN_W  = logicnets_pkg::IN_W,
  parameter int OUT_W = logicnets_pkg::OUT_W,
  parameter int PACK  = logicnets_pkg::PACK,
  parameter int BEAT_W = 1
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [BEAT_W-1:0]       i_wbeat,
  input  logic [PACK*OUT_W-1:0]   i_wdata,
  input  logic [IN_W-1:0]         i_raddr,
  output logic [OUT_W-1:0]        o_rdata
);

  localparam int DEPTH = 1 << IN_W;

  logic [OUT_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int j = 0; j < PACK; j++) begin
        r_mem[IN_W'(int'(i_wbeat) * PACK + j)] <= i_wdata[j*OUT_W +: OUT_W];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/logicnets_lut_loadable.sv
// Loadable LogicNets neuron: config-stream framing FSM, table RAM and a
// one-cycle registered lookup path.
module logicnets_lut_loadable
  import logicnets_pkg::*;
#(
  parameter int IN_W  = logicnets_pkg::IN_W,
  parameter int OUT_W = logicnets_pkg::OUT_W,
  parameter int PACK  = logicnets_pkg::PACK
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [PACK*OUT_W-1:0] i_cfg_data,
  input  logic                  i_cfg_last,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [IN_W-1:0]       i_in_data,
  output logic                  o_out_valid,
  output logic [OUT_W-1:0]      o_out_data,
  output logic                  o_table_ok,
  output logic                  o_load_err
);

  localparam int NBeats = (1 << IN_W) / PACK;
  localparam int BEAT_W = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(NBeats - 1);

  state_t            r_state, w_stateNext;
  logic [BEAT_W-1:0] r_beatCnt, w_beatNext, w_curBeat;
  logic              r_cfgReady, r_tableOk, r_loadErr, r_outValid;
  logic [OUT_W-1:0]  r_outData;
  logic              w_tableOkNext, w_loadErrNext, w_we;
  logic              w_cfgAccept, w_inAccept;
  logic [OUT_W-1:0]  w_rdata;

  assign w_cfgAccept = i_cfg_valid & r_cfgReady;
  assign w_inAccept  = i_in_valid & (r_state == RUN);

  // A beat arriving outside LOAD restarts the table at beat 0; framing is
  // judged against the beat index it would occupy.
  always_comb begin
    w_stateNext   = r_state;
    w_beatNext    = r_beatCnt;
    w_tableOkNext = r_tableOk;
    w_loadErrNext = r_loadErr;
    w_we          = 1'b0;
    w_curBeat     = (r_state == LOAD) ? r_beatCnt : '0;
    if (w_cfgAccept) begin
      w_tableOkNext = 1'b0;
      w_loadErrNext = 1'b0;
      if ((w_curBeat == LastBeat) && i_cfg_last) begin
        w_we        = 1'b1;
        w_stateNext = RUN;
        w_beatNext  = '0;
        w_tableOkNext = 1'b1;
      end else if ((w_curBeat != LastBeat) && !i_cfg_last) begin
        w_we        = 1'b1;
        w_stateNext = LOAD;
        w_beatNext  = w_curBeat + 1'b1;
      end else begin
        w_stateNext   = EMPTY;
        w_beatNext    = '0;
        w_loadErrNext = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= EMPTY;
      r_beatCnt  <= '0;
      r_cfgReady <= 1'b0;
      r_tableOk  <= 1'b0;
      r_loadErr  <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_beatCnt  <= w_beatNext;
      r_cfgReady <= 1'b1;
      r_tableOk  <= w_tableOkNext;
      r_loadErr  <= w_loadErrNext;
      r_outValid <= w_inAccept;
      if (w_inAccept) begin
        r_outData <= w_rdata;
      end
    end
  end

  // Asynchronous read, so a lookup colliding with a write sees old contents.
  logicnets_lut_ram #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .PACK  (PACK),
    .BEAT_W(BEAT_W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_wbeat(w_curBeat),
    .i_wdata(i_cfg_data),
    .i_raddr(i_in_data),
    .o_rdata(w_rdata)
  );

  assign o_cfg_ready = r_cfgReady;
  assign o_in_ready  = (r_state == RUN);
  assign o_out_valid = r_outValid;
  assign o_out_data  = r_outData;
  assign o_table_ok  = r_tableOk;
  assign o_load_err  = r_loadErr;

endmodule

// File: tb/tb_logicnets_lut_loadable.sv
// Directed bench for logicnets_lut_loadable: framing cases, lookup sweep,
// reload collision and reset mid-load.
module tb_logicnets_lut_loadable;

  localparam int IN_W  = 7;
  localparam int OUT_W = 2;
  localparam int PACK  = 8;
  localparam int NB    = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cfgValid = 1'b0;
  logic                  cfgReady;
  logic [PACK*OUT_W-1:0] cfgData = '0;
  logic                  cfgLast = 1'b0;
  logic                  inValid = 1'b0;
  logic                  inReady;
  logic [IN_W-1:0]       inData = '0;
  logic                  outValid;
  logic [OUT_W-1:0]      outData;
  logic                  tableOk;
  logic                  loadErr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IN_W-1:0]  idx;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  logicnets_lut_loadable dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cfg_valid(cfgValid),
    .o_cfg_ready(cfgReady),
    .i_cfg_data (cfgData),
    .i_cfg_last (cfgLast),
    .i_in_valid (inValid),
    .o_in_ready (inReady),
    .i_in_data  (inData),
    .o_out_valid(outValid),
    .o_out_data (outData),
    .o_table_ok (tableOk),
    .o_load_err (loadErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Table patterns: 0 -> i[1:0], 1 -> all 3, 2 -> all 0, 3 -> (i>>1)[1:0]
  function automatic logic [OUT_W-1:0] entryVal(input int mode, input int i);
    case (mode)
      0:       return OUT_W'(i);
      1:       return 2'b11;
      2:       return 2'b00;
      default: return OUT_W'(i >> 1);
    endcase
  endfunction

  function automatic logic [PACK*OUT_W-1:0] beatData(input int mode, input int k);
    logic [PACK*OUT_W-1:0] d;
    d = '0;
    for (int j = 0; j < PACK; j++) d[j*OUT_W +: OUT_W] = entryVal(mode, k * PACK + j);
    return d;
  endfunction

  task automatic applyStimulus(input int mode, input int k, input logic last);
    cfgValid = 1'b1;
    cfgData  = beatData(mode, k);
    cfgLast  = last;
    tick();
    cfgValid = 1'b0;
    cfgLast  = 1'b0;
  endtask

  task automatic loadTable(input int mode);
    for (int k = 0; k < NB; k++) applyStimulus(mode, k, k == NB - 1);
  endtask

  initial begin
    int bad;
    int pulses;

    vecs[0] = '{idx: 7'd0,   exp: 2'd0};
    vecs[1] = '{idx: 7'd3,   exp: 2'd1};
    vecs[2] = '{idx: 7'd4,   exp: 2'd2};
    vecs[3] = '{idx: 7'd7,   exp: 2'd3};
    vecs[4] = '{idx: 7'd8,   exp: 2'd0};
    vecs[5] = '{idx: 7'd127, exp: 2'd3};
    vecs[6] = '{idx: 7'd64,  exp: 2'd0};
    vecs[7] = '{idx: 7'd85,  exp: 2'd2};

    // Reset and idle with a pending request
    inValid = 1'b1;
    inData  = 7'd5;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("cfg_ready_before_edge", int'(cfgReady), 0);
    tick();
    checkOutput("cfg_ready_after_release", int'(cfgReady), 1);
    checkOutput("in_ready_idle", int'(inReady), 0);
    checkOutput("out_valid_idle", int'(outValid), 0);
    checkOutput("table_ok_idle", int'(tableOk), 0);
    checkOutput("load_err_idle", int'(loadErr), 0);
    checkOutput("out_data_idle", int'(outData), 0);
    tick();
    checkOutput("out_valid_idle2", int'(outValid), 0);
    inValid = 1'b0;

    // Full load and back-to-back sweep
    loadTable(0);
    checkOutput("full_table_ok", int'(tableOk), 1);
    checkOutput("full_in_ready", int'(inReady), 1);
    checkOutput("full_load_err", int'(loadErr), 0);
    bad = 0;
    pulses = 0;
    for (int i = 0; i < 128; i++) begin
      inValid = 1'b1;
      inData  = IN_W'(i);
      tick();
      if (outValid === 1'b1) pulses++;
      if (outData !== OUT_W'(i)) bad++;
    end
    inValid = 1'b0;
    checkOutput("sweep_data_errors", bad, 0);
    checkOutput("sweep_pulses", pulses, 128);
    tick();
    checkOutput("sweep_idle_valid", int'(outValid), 0);
    checkOutput("sweep_hold_data", int'(outData), 3);

    // Early last on beat 3
    for (int k = 0; k < 3; k++) applyStimulus(2, k, 1'b0);
    checkOutput("early_table_ok_mid", int'(tableOk), 0);
    applyStimulus(2, 3, 1'b1);
    checkOutput("early_load_err", int'(loadErr), 1);
    checkOutput("early_table_ok", int'(tableOk), 0);
    checkOutput("early_in_ready", int'(inReady), 0);
    applyStimulus(0, 0, 1'b0);
    checkOutput("early_err_cleared", int'(loadErr), 0);
    for (int k = 1; k < NB; k++) applyStimulus(0, k, k == NB - 1);
    checkOutput("early_recover_ok", int'(tableOk), 1);

    // Missing last on beat 15
    for (int k = 0; k < NB; k++) applyStimulus(1, k, 1'b0);
    checkOutput("missing_load_err", int'(loadErr), 1);
    checkOutput("missing_table_ok", int'(tableOk), 0);
    checkOutput("missing_in_ready", int'(inReady), 0);
    inValid = 1'b1;
    inData  = 7'd1;
    tick();
    inValid = 1'b0;
    checkOutput("missing_no_result", int'(outValid), 0);

    // Reload collision
    loadTable(1);
    checkOutput("coll_table_ok", int'(tableOk), 1);
    inValid = 1'b1;
    inData  = 7'd9;
    applyStimulus(2, 0, 1'b0);
    checkOutput("coll_out_valid", int'(outValid), 1);
    checkOutput("coll_out_old", int'(outData), 3);
    checkOutput("coll_in_ready_drop", int'(inReady), 0);
    bad = 0;
    for (int k = 1; k < NB; k++) begin
      if (inReady !== 1'b0) bad++;
      applyStimulus(2, k, k == NB - 1);
      if ((k < NB - 1) && (outValid !== 1'b0)) bad++;
    end
    checkOutput("coll_blocked_during_load", bad, 0);
    checkOutput("coll_in_ready_back", int'(inReady), 1);
    tick();
    inValid = 1'b0;
    checkOutput("coll_new_valid", int'(outValid), 1);
    checkOutput("coll_new_data", int'(outData), 0);

    // Table-driven lookups against pattern 3
    loadTable(3);
    for (int v = 0; v < 8; v++) begin
      inValid = 1'b1;
      inData  = vecs[v].idx;
      tick();
      checkOutput($sformatf("vec%0d_valid", v), int'(outValid), 1);
      checkOutput($sformatf("vec%0d_data", v), int'(outData), int'(vecs[v].exp));
    end
    inValid = 1'b0;

    // Reset mid-load
    for (int k = 0; k < 8; k++) applyStimulus(0, k, 1'b0);
    checkOutput("midrst_hold_data", int'(outData), 2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_cfg_ready", int'(cfgReady), 0);
    checkOutput("midrst_out_data", int'(outData), 0);
    checkOutput("midrst_out_valid", int'(outValid), 0);
    checkOutput("midrst_table_ok", int'(tableOk), 0);
    checkOutput("midrst_load_err", int'(loadErr), 0);
    checkOutput("midrst_in_ready", int'(inReady), 0);
    tick();
    rst = 1'b0;
    tick();
    loadTable(3);
    checkOutput("midrst_reload_ok", int'(tableOk), 1);
    checkOutput("midrst_reload_err", int'(loadErr), 0);
    inValid = 1'b1;
    inData  = 7'd6;
    tick();
    inValid = 1'b0;
    checkOutput("midrst_lookup", int'(outData), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
